// File: rtl/fft_mag_reader_if.sv
// Bus bundle between fft_mag_reader, its source FIFO read port and its output stream sink.
// master = the magnitude reader, slave = FIFO/sink side.
interface fft_mag_reader_if #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned OUT_W  = 32,
    parameter int unsigned BIN_W  = 10
);
    logic              fifo_rd_en;
    logic [DATA_W-1:0] fifo_rd_data;
    logic              fifo_rd_empty;
    logic              m_valid;
    logic              m_ready;
    logic [OUT_W-1:0]  m_mag;
    logic [BIN_W-1:0]  m_bin;
    logic              m_last;

    modport master (
        output fifo_rd_en,
        input  fifo_rd_data,
        input  fifo_rd_empty,
        output m_valid,
        input  m_ready,
        output m_mag,
        output m_bin,
        output m_last
    );

    modport slave (
        input  fifo_rd_en,
        output fifo_rd_data,
        output fifo_rd_empty,
        input  m_valid,
        output m_ready,
        input  m_mag,
        input  m_bin,
        input  m_last
    );
endinterface

// File: rtl/fft_mag_reader.sv
// Drains complex FFT bins from a 1-cycle-latency sync FIFO, emits saturated (re^2+im^2)>>SHIFT
// as a valid/ready stream tagged with bin index and frame-last, under credit-based read control.
module fft_mag_reader #(
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned FFT_POINTS = 1024,
    parameter int unsigned SHIFT      = 32,
    parameter int unsigned OUT_W      = 32,
    parameter int unsigned BUF_DEPTH  = 4
) (
    input  logic             clk,
    input  logic             tb_rst,
    input  logic             enable,
    fft_mag_reader_if.master bus,
    output logic             frame_done,
    output logic             busy
);
    localparam int unsigned HALF_W = DATA_W / 2;
    localparam int unsigned BIN_W  = $clog2(FFT_POINTS);
    localparam int unsigned PTR_W  = $clog2(BUF_DEPTH);
    localparam int unsigned CNT_W  = $clog2(BUF_DEPTH + 1);
    localparam int unsigned ENT_W  = OUT_W + BIN_W + 1;

    localparam logic [BIN_W-1:0] LAST_BIN   = BIN_W'(FFT_POINTS - 1);
    localparam logic [CNT_W-1:0] CREDIT_MAX = CNT_W'(BUF_DEPTH);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t            state;
    logic [BIN_W-1:0]  rd_bin;
    logic [CNT_W-1:0]  credit;
    logic [CNT_W-1:0]  credit_nxt_c;
    logic              rd_en_c;
    logic              xfer_c;
    logic              last_read_c;
    logic              run_nxt_c;

    // Tag stage (cycle after read issue) and data capture stage
    logic              p0_valid;
    logic [BIN_W-1:0]  p0_bin;
    logic              p0_last;
    logic              s0_valid;
    logic [DATA_W-1:0] s0_data;
    logic [BIN_W-1:0]  s0_bin;
    logic              s0_last;

    // Magnitude datapath
    logic signed [DATA_W-1:0] re_w_c;
    logic signed [DATA_W-1:0] im_w_c;
    logic signed [DATA_W-1:0] sq_re_c;
    logic signed [DATA_W-1:0] sq_im_c;
    logic [DATA_W-1:0]        sum_c;
    logic [DATA_W-1:0]        shifted_c;
    logic [OUT_W-1:0]         mag_c;
    logic [ENT_W-1:0]         push_ent_c;

    // Output buffer: the m_* registers are the head entry, mem holds the rest
    logic [ENT_W-1:0]  mem [BUF_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  buf_cnt;
    logic              out_free_c;
    logic              buf_rd_c;
    logic              buf_wr_c;

    // Credits cover every read in the pipeline plus every buffered beat, so the buffer cannot overflow
    assign rd_en_c        = (state == S_RUN) && !bus.fifo_rd_empty && (credit < CREDIT_MAX);
    assign bus.fifo_rd_en = rd_en_c;
    assign xfer_c         = bus.m_valid && bus.m_ready;
    assign last_read_c    = rd_en_c && (rd_bin == LAST_BIN);
    assign run_nxt_c      = (state == S_IDLE) ? enable : !(last_read_c && !enable);

    always_comb begin
        credit_nxt_c = credit;
        if (rd_en_c && !xfer_c) begin
            credit_nxt_c = credit + CNT_W'(1);
        end else if (!rd_en_c && xfer_c) begin
            credit_nxt_c = credit - CNT_W'(1);
        end
    end

    // Frame FSM, read bin counter, credit counter and busy flag
    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            state  <= S_IDLE;
            rd_bin <= '0;
            credit <= '0;
            busy   <= 1'b0;
        end else begin
            state  <= run_nxt_c ? S_RUN : S_IDLE;
            credit <= credit_nxt_c;
            busy   <= run_nxt_c || (credit_nxt_c != '0);
            if (rd_en_c) begin
                rd_bin <= rd_bin + BIN_W'(1);
            end
        end
    end

    // Bin tag follows the read; FIFO data is captured the cycle after the read
    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            p0_valid <= 1'b0;
            p0_bin   <= '0;
            p0_last  <= 1'b0;
            s0_valid <= 1'b0;
            s0_data  <= '0;
            s0_bin   <= '0;
            s0_last  <= 1'b0;
        end else begin
            p0_valid <= rd_en_c;
            p0_bin   <= rd_bin;
            p0_last  <= (rd_bin == LAST_BIN);
            s0_valid <= p0_valid;
            if (p0_valid) begin
                s0_data <= bus.fifo_rd_data;
                s0_bin  <= p0_bin;
                s0_last <= p0_last;
            end
        end
    end

    // Squares, sum, shift and saturate in one stage to keep read-to-valid latency at 3 cycles
    always_comb begin
        re_w_c    = $signed({{HALF_W{s0_data[DATA_W-1]}}, s0_data[DATA_W-1:HALF_W]});
        im_w_c    = $signed({{HALF_W{s0_data[HALF_W-1]}}, s0_data[HALF_W-1:0]});
        sq_re_c   = re_w_c * re_w_c;
        sq_im_c   = im_w_c * im_w_c;
        sum_c     = $unsigned(sq_re_c) + $unsigned(sq_im_c);
        shifted_c = sum_c >> SHIFT;
        mag_c     = ((shifted_c >> OUT_W) != '0) ? '1 : shifted_c[OUT_W-1:0];
        push_ent_c = {mag_c, s0_bin, s0_last};
    end

    assign out_free_c = !bus.m_valid || bus.m_ready;
    assign buf_rd_c   = out_free_c && (buf_cnt != '0);
    assign buf_wr_c   = s0_valid && !(out_free_c && (buf_cnt == '0));

    always_ff @(posedge clk) begin
        if (buf_wr_c) begin
            mem[wr_ptr] <= push_ent_c;
        end
    end

    // Output head register: refilled from the buffer first, else bypassed from the datapath
    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            bus.m_valid <= 1'b0;
            bus.m_mag   <= '0;
            bus.m_bin   <= '0;
            bus.m_last  <= 1'b0;
            frame_done  <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            buf_cnt     <= '0;
        end else begin
            frame_done <= xfer_c && bus.m_last;
            if (buf_wr_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (buf_rd_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (buf_wr_c && !buf_rd_c) begin
                buf_cnt <= buf_cnt + CNT_W'(1);
            end else if (!buf_wr_c && buf_rd_c) begin
                buf_cnt <= buf_cnt - CNT_W'(1);
            end
            if (out_free_c) begin
                if (buf_rd_c) begin
                    {bus.m_mag, bus.m_bin, bus.m_last} <= mem[rd_ptr];
                    bus.m_valid <= 1'b1;
                end else if (s0_valid) begin
                    {bus.m_mag, bus.m_bin, bus.m_last} <= push_ent_c;
                    bus.m_valid <= 1'b1;
                end else begin
                    bus.m_valid <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_fft_mag_reader.sv
// Randomized bench for fft_mag_reader: FIFO and sink models drive two instances (SHIFT=0, SHIFT=32)
// and a queue-based reference predicts every output beat.
module tb_fft_mag_reader;
    localparam int unsigned BUF_DEPTH = 4;
    localparam int unsigned NA = 1024;
    localparam int unsigned NB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic tb_rst = 1'b1;
    logic en_a   = 1'b1;
    logic en_b   = 1'b1;
    logic fd_a, busy_a, fd_b, busy_b;

    logic [63:0] a_data  = '0;
    logic        a_empty = 1'b1;
    logic        ready_a = 1'b1;
    logic [63:0] b_data  = '0;
    logic        b_empty = 1'b1;

    fft_mag_reader_if #(.DATA_W(64), .OUT_W(32), .BIN_W(10)) bus_a ();
    fft_mag_reader_if #(.DATA_W(64), .OUT_W(32), .BIN_W(2))  bus_b ();

    assign bus_a.fifo_rd_data  = a_data;
    assign bus_a.fifo_rd_empty = a_empty;
    assign bus_a.m_ready       = ready_a;
    assign bus_b.fifo_rd_data  = b_data;
    assign bus_b.fifo_rd_empty = b_empty;
    assign bus_b.m_ready       = 1'b1;

    fft_mag_reader #(.DATA_W(64), .FFT_POINTS(NA), .SHIFT(0), .OUT_W(32), .BUF_DEPTH(BUF_DEPTH)) dut_a (
        .clk(clk), .tb_rst(tb_rst), .enable(en_a), .bus(bus_a), .frame_done(fd_a), .busy(busy_a));
    fft_mag_reader #(.DATA_W(64), .FFT_POINTS(NB), .SHIFT(32), .OUT_W(32), .BUF_DEPTH(BUF_DEPTH)) dut_b (
        .clk(clk), .tb_rst(tb_rst), .enable(en_b), .bus(bus_b), .frame_done(fd_b), .busy(busy_b));

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference magnitude: plain integer arithmetic, saturate by value comparison
    function automatic logic [31:0] mag_f(input logic [63:0] w, input int sh);
        logic signed [31:0] r, i;
        longint rr, ii;
        logic [63:0] s;
        r  = w[63:32];
        i  = w[31:0];
        rr = longint'(r);
        ii = longint'(i);
        s  = $unsigned(rr * rr) + $unsigned(ii * ii);
        s  = s >> sh;
        return (s > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    // FIFO A model: 1-cycle read latency, source words trickle in with random gaps
    logic [63:0] fifo_q[$];
    logic [63:0] src_q[$];
    logic [63:0] rdw_q[$];
    int unsigned gap_pct   = 0;
    int unsigned ready_pct = 100;
    int          reads_a   = 0;

    always @(posedge clk) begin
        logic [63:0] w;
        if (bus_a.fifo_rd_en) begin
            reads_a++;
            if (fifo_q.size() > 0) begin
                w = fifo_q.pop_front();
                a_data <= w;
                rdw_q.push_back(w);
            end
        end
        if (src_q.size() > 0 && $urandom_range(99) >= gap_pct) begin
            fifo_q.push_back(src_q.pop_front());
        end
        a_empty <= (fifo_q.size() == 0);
    end

    always @(posedge clk) begin
        #1;
        ready_a = ($urandom_range(99) < ready_pct);
    end

    logic [63:0] bfifo_q[$];
    logic [63:0] bw_q[$];
    always @(posedge clk) begin
        logic [63:0] w;
        if (bus_b.fifo_rd_en && bfifo_q.size() > 0) begin
            w = bfifo_q.pop_front();
            b_data <= w;
            bw_q.push_back(w);
        end
        b_empty <= (bfifo_q.size() == 0);
    end

    // Compare process for instance A
    int          cyc = 0;
    int          out_a = 0;
    int          bin_a = 0;
    int          beats_a = 0;
    int          fdcnt_a = 0;
    logic        fd_exp_a = 1'b0;
    logic        lit_en = 1'b0;
    logic [31:0] lit_mag = '0;
    logic        lat_arm = 1'b0;
    int          first_rd = -1;
    int          first_val = -1;

    always @(negedge clk) begin
        cyc++;
        if (tb_rst) begin
            rdw_q.delete();
            out_a    = 0;
            bin_a    = 0;
            fd_exp_a = 1'b0;
        end else begin
            if (lat_arm && bus_a.fifo_rd_en && first_rd < 0) first_rd = cyc;
            if (lat_arm && bus_a.m_valid && first_val < 0) first_val = cyc;
            if (bus_a.fifo_rd_en) begin
                check("rd_en_while_empty", 64'(a_empty), 64'(0));
                check("rd_en_at_full_credit", 64'(out_a >= int'(BUF_DEPTH)), 64'(0));
            end
            check("frame_done", 64'(fd_a), 64'(fd_exp_a));
            if (fd_a) fdcnt_a++;
            fd_exp_a = 1'b0;
            if (bus_a.m_valid) begin
                if (rdw_q.size() == 0) begin
                    check("spurious_valid", 64'(1), 64'(0));
                end else begin
                    check("mag", 64'(bus_a.m_mag), 64'(mag_f(rdw_q[0], 0)));
                    check("bin", 64'(bus_a.m_bin), 64'(bin_a));
                    check("last", 64'(bus_a.m_last), 64'(bin_a == int'(NA - 1)));
                    if (lit_en) check("mag_literal", 64'(bus_a.m_mag), 64'(lit_mag));
                    if (bus_a.m_ready) begin
                        void'(rdw_q.pop_front());
                        beats_a++;
                        if (bin_a == int'(NA - 1)) fd_exp_a = 1'b1;
                        bin_a = (bin_a + 1) % int'(NA);
                    end
                end
            end
            if (bus_a.fifo_rd_en && !(bus_a.m_valid && bus_a.m_ready)) out_a++;
            if (!bus_a.fifo_rd_en && bus_a.m_valid && bus_a.m_ready) out_a--;
        end
    end

    // Compare process for instance B (SHIFT=32, 4-bin frames, sink always ready)
    int bin_b = 0;
    int beats_b = 0;
    always @(negedge clk) begin
        if (tb_rst) begin
            bw_q.delete();
            bin_b = 0;
        end else begin
            if (bus_b.fifo_rd_en) check("b_rd_en_while_empty", 64'(b_empty), 64'(0));
            if (bus_b.m_valid) begin
                if (bw_q.size() == 0) begin
                    check("b_spurious_valid", 64'(1), 64'(0));
                end else begin
                    check("b_mag", 64'(bus_b.m_mag), 64'(mag_f(bw_q[0], 32)));
                    check("b_bin", 64'(bus_b.m_bin), 64'(bin_b));
                    check("b_last", 64'(bus_b.m_last), 64'(bin_b == int'(NB - 1)));
                    if (beats_b < 4) check("b_sat_literal", 64'(bus_b.m_mag), 64'h8000_0000);
                    void'(bw_q.pop_front());
                    beats_b++;
                    bin_b = (bin_b + 1) % int'(NB);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [63:0] rand_word();
        logic [63:0] w;
        w = {$urandom, $urandom};
        if ($urandom_range(9) == 0) w = 64'h8000_0000_8000_0000;
        return w;
    endfunction

    initial begin
        int base;
        for (int i = 0; i < 8; i++) fifo_q.push_back(rand_word());
        #200;
        // Reset held with FIFO non-empty and enable high
        check("rst_m_valid", 64'(bus_a.m_valid), 64'(0));
        check("rst_m_mag", 64'(bus_a.m_mag), 64'(0));
        check("rst_m_bin", 64'(bus_a.m_bin), 64'(0));
        check("rst_m_last", 64'(bus_a.m_last), 64'(0));
        check("rst_frame_done", 64'(fd_a), 64'(0));
        check("rst_busy", 64'(busy_a), 64'(0));
        check("rst_rd_en", 64'(bus_a.fifo_rd_en), 64'(0));

        // One frame of re=3, im=-4
        fifo_q.delete();
        for (int i = 0; i < int'(NA); i++) fifo_q.push_back({32'd3, 32'hFFFF_FFFC});
        for (int i = 0; i < 4; i++) bfifo_q.push_back(64'h8000_0000_8000_0000);
        for (int i = 0; i < 8; i++) bfifo_q.push_back(rand_word());
        lit_mag = 32'd25;
        lit_en  = 1'b1;
        lat_arm = 1'b1;
        @(posedge clk);
        #1;
        tb_rst = 1'b0;
        tick(1);
        en_a = 1'b0;
        for (int i = 0; i < 3000 && fdcnt_a < 1; i++) tick(1);
        tick(5);
        lit_en = 1'b0;
        check("t2_frame_done_count", 64'(fdcnt_a), 64'(1));
        check("t2_beats", 64'(beats_a), 64'(NA));
        check("t2_latency", 64'(first_val - first_rd), 64'(3));
        check("t2_busy_idle", 64'(busy_a), 64'(0));
        check("b_beats", 64'(beats_b), 64'(12));

        // Saturation at SHIFT=0, then backpressure and starvation; enable dropped at bin 500
        en_a = 1'b1;
        for (int i = 0; i < 4; i++) fifo_q.push_back(64'h8000_0000_8000_0000);
        lit_mag = 32'hFFFF_FFFF;
        lit_en  = 1'b1;
        for (int i = 0; i < 100 && beats_a < int'(NA) + 4; i++) tick(1);
        lit_en = 1'b0;
        check("t3_sat_beats", 64'(beats_a), 64'(NA + 4));
        ready_pct = 50;
        gap_pct   = 30;
        for (int i = 0; i < int'(NA) - 4; i++) src_q.push_back(rand_word());
        for (int i = 0; i < 5000 && reads_a < int'(NA) + 500; i++) tick(1);
        en_a = 1'b0;
        for (int i = 0; i < 6000 && fdcnt_a < 2; i++) tick(1);
        tick(5);
        check("t4_frame_done_count", 64'(fdcnt_a), 64'(2));
        check("t4_beats", 64'(beats_a), 64'(2 * NA));
        check("t6_busy_idle", 64'(busy_a), 64'(0));

        // Idle with data waiting: no reads while enable is low
        for (int i = 0; i < 10; i++) fifo_q.push_back(rand_word());
        tick(20);
        check("t6_idle_no_reads", 64'(reads_a), 64'(2 * NA));

        // Mid-frame reset, then a fresh frame must restart at bin 0
        ready_pct = 100;
        gap_pct   = 0;
        en_a      = 1'b1;
        for (int i = 0; i < 40; i++) src_q.push_back(rand_word());
        for (int i = 0; i < 200 && beats_a < 2 * int'(NA) + 20; i++) tick(1);
        tb_rst = 1'b1;
        #2;
        check("mid_rst_m_valid", 64'(bus_a.m_valid), 64'(0));
        check("mid_rst_busy", 64'(busy_a), 64'(0));
        check("mid_rst_rd_en", 64'(bus_a.fifo_rd_en), 64'(0));
        check("mid_rst_m_bin", 64'(bus_a.m_bin), 64'(0));
        fifo_q.delete();
        src_q.delete();
        tick(2);
        tb_rst    = 1'b0;
        ready_pct = 70;
        gap_pct   = 10;
        for (int i = 0; i < int'(NA); i++) src_q.push_back(rand_word());
        for (int i = 0; i < 200 && !bus_a.m_valid; i++) tick(1);
        check("restart_valid", 64'(bus_a.m_valid), 64'(1));
        check("restart_bin", 64'(bus_a.m_bin), 64'(0));
        base = reads_a;
        for (int i = 0; i < 1000 && reads_a < base + 100; i++) tick(1);
        en_a = 1'b0;
        for (int i = 0; i < 5000 && fdcnt_a < 3; i++) tick(1);
        tick(5);
        check("final_frame_done_count", 64'(fdcnt_a), 64'(3));
        check("final_busy", 64'(busy_a), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
